// File: rtl/fnd_time_adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fnd_time_adjust_ctrl
// Purpose  : Edit-mode sequencer for the FND clock display. Captures the
//            running time into shadow registers, lets the user step through
//            hour -> min -> sec and increment/decrement each field, blinks
//            the selected field and commits the result with a one-cycle
//            load strobe. Inactivity aborts the edit without loading.
// Revision : 1.0 - initial release
//
// Ports:
//   clk                 system clock
//   rst                 asynchronous reset, active-low
//   i_tick_1khz         1 kHz single-cycle enable
//   i_btn_mode          enter edit / commit pulse
//   i_btn_next          advance to next field pulse
//   i_btn_up            increment selected field pulse
//   i_btn_down          decrement selected field pulse
//   i_cur_hour/min/sec  running time
//   o_disp_hour/min/sec time to display (running time in IDLE, shadows else)
//   o_adjust_digit_sel  one-hot field select (bit1 hour, bit2 min, bit3 sec)
//   o_blink_on          blink phase, 1 = selected field visible
//   o_edit_active       high in any edit state
//   o_load_en           one-cycle commit strobe
//   o_load_hour/min/sec committed time, held between commits
// ============================================================================
module fnd_time_adjust_ctrl #(
  parameter int BLINK_HALF    = 250,
  parameter int TIMEOUT_TICKS = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick_1khz,
  input  logic       i_btn_mode,
  input  logic       i_btn_next,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic [4:0] i_cur_hour,
  input  logic [5:0] i_cur_min,
  input  logic [5:0] i_cur_sec,
  output logic [4:0] o_disp_hour,
  output logic [5:0] o_disp_min,
  output logic [5:0] o_disp_sec,
  output logic [3:0] o_adjust_digit_sel,
  output logic       o_blink_on,
  output logic       o_edit_active,
  output logic       o_load_en,
  output logic [4:0] o_load_hour,
  output logic [5:0] o_load_min,
  output logic [5:0] o_load_sec
);

  localparam int c_BW = (BLINK_HALF    > 1) ? $clog2(BLINK_HALF)    : 1;
  localparam int c_TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_HALF - 1);
  localparam logic [c_TW-1:0] c_TO_LAST    = c_TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EDIT_HOUR = 3'd1,
    ST_EDIT_MIN  = 3'd2,
    ST_EDIT_SEC  = 3'd3,
    ST_COMMIT    = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [4:0]      r_hour, w_hour_nxt;
  logic [5:0]      r_min,  w_min_nxt;
  logic [5:0]      r_sec,  w_sec_nxt;
  logic [c_BW-1:0] r_bcnt, w_bcnt_nxt;
  logic [c_TW-1:0] r_tcnt, w_tcnt_nxt;
  logic            r_blink_on, w_blink_nxt;
  logic [3:0]      r_sel, w_sel_nxt;
  logic            r_edit, w_edit_nxt;
  logic            r_load_en;
  logic [4:0]      r_load_hour;
  logic [5:0]      r_load_min;
  logic [5:0]      r_load_sec;

  logic            w_any_btn;
  logic [4:0]      w_hour_inc, w_hour_dec;
  logic [5:0]      w_min_inc,  w_min_dec;
  logic [5:0]      w_sec_inc,  w_sec_dec;

  assign w_any_btn = i_btn_mode | i_btn_next | i_btn_up | i_btn_down;

  // Wrapping step functions. Out-of-range values snap to the wrap target
  // in the direction of travel (0 going up, MAX going down).
  assign w_hour_inc = (r_hour >= 5'd23) ? 5'd0  : r_hour + 5'd1;
  assign w_hour_dec = ((r_hour == 5'd0) || (r_hour > 5'd23)) ? 5'd23 : r_hour - 5'd1;
  assign w_min_inc  = (r_min  >= 6'd59) ? 6'd0  : r_min  + 6'd1;
  assign w_min_dec  = ((r_min  == 6'd0) || (r_min  > 6'd59)) ? 6'd59 : r_min  - 6'd1;
  assign w_sec_inc  = (r_sec  >= 6'd59) ? 6'd0  : r_sec  + 6'd1;
  assign w_sec_dec  = ((r_sec  == 6'd0) || (r_sec  > 6'd59)) ? 6'd59 : r_sec  - 6'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_hour      <= '0;
      r_min       <= '0;
      r_sec       <= '0;
      r_bcnt      <= '0;
      r_tcnt      <= '0;
      r_blink_on  <= 1'b0;
      r_sel       <= '0;
      r_edit      <= 1'b0;
      r_load_en   <= 1'b0;
      r_load_hour <= '0;
      r_load_min  <= '0;
      r_load_sec  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hour     <= w_hour_nxt;
      r_min      <= w_min_nxt;
      r_sec      <= w_sec_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_blink_on <= w_blink_nxt;
      r_sel      <= w_sel_nxt;
      r_edit     <= w_edit_nxt;
      r_load_en  <= (w_state_nxt == ST_COMMIT);
      // Shadows do not change on the commit cycle, so the current shadows
      // are exactly what gets committed.
      if (w_state_nxt == ST_COMMIT) begin
        r_load_hour <= r_hour;
        r_load_min  <= r_min;
        r_load_sec  <= r_sec;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hour_nxt  = r_hour;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_bcnt_nxt  = r_bcnt;
    w_tcnt_nxt  = r_tcnt;
    w_blink_nxt = r_blink_on;
    w_sel_nxt   = 4'b0000;
    w_edit_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_btn_mode) begin
          w_state_nxt = ST_EDIT_HOUR;
          w_hour_nxt  = i_cur_hour;
          w_min_nxt   = i_cur_min;
          w_sec_nxt   = i_cur_sec;
          w_bcnt_nxt  = '0;
          w_tcnt_nxt  = '0;
          w_blink_nxt = 1'b1;
        end
      end

      ST_EDIT_HOUR, ST_EDIT_MIN, ST_EDIT_SEC: begin
        if (w_any_btn) begin
          // Any activity restarts both counters, even if a tick coincides.
          w_bcnt_nxt  = '0;
          w_tcnt_nxt  = '0;
          w_blink_nxt = 1'b1;
          if (i_btn_mode) begin
            w_state_nxt = ST_COMMIT;
          end else if (i_btn_next) begin
            case (r_state)
              ST_EDIT_HOUR: w_state_nxt = ST_EDIT_MIN;
              ST_EDIT_MIN:  w_state_nxt = ST_EDIT_SEC;
              default:      w_state_nxt = ST_EDIT_HOUR;
            endcase
          end else if (i_btn_up) begin
            case (r_state)
              ST_EDIT_HOUR: w_hour_nxt = w_hour_inc;
              ST_EDIT_MIN:  w_min_nxt  = w_min_inc;
              default:      w_sec_nxt  = w_sec_inc;
            endcase
          end else begin
            case (r_state)
              ST_EDIT_HOUR: w_hour_nxt = w_hour_dec;
              ST_EDIT_MIN:  w_min_nxt  = w_min_dec;
              default:      w_sec_nxt  = w_sec_dec;
            endcase
          end
        end else if (i_tick_1khz) begin
          if (r_tcnt == c_TO_LAST) begin
            w_state_nxt = ST_IDLE;
            w_tcnt_nxt  = '0;
            w_bcnt_nxt  = '0;
          end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
            if (r_bcnt == c_BLINK_LAST) begin
              w_bcnt_nxt  = '0;
              w_blink_nxt = ~r_blink_on;
            end else begin
              w_bcnt_nxt = r_bcnt + 1'b1;
            end
          end
        end
      end

      ST_COMMIT: w_state_nxt = ST_IDLE;

      default:   w_state_nxt = ST_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up
    // with the state they describe.
    case (w_state_nxt)
      ST_EDIT_HOUR: begin w_sel_nxt = 4'b0010; w_edit_nxt = 1'b1; end
      ST_EDIT_MIN:  begin w_sel_nxt = 4'b0100; w_edit_nxt = 1'b1; end
      ST_EDIT_SEC:  begin w_sel_nxt = 4'b1000; w_edit_nxt = 1'b1; end
      default:      begin w_sel_nxt = 4'b0000; w_edit_nxt = 1'b0; end
    endcase
    if (!w_edit_nxt) begin
      w_blink_nxt = 1'b0;
    end
  end

  assign o_disp_hour        = (r_state == ST_IDLE) ? i_cur_hour : r_hour;
  assign o_disp_min         = (r_state == ST_IDLE) ? i_cur_min  : r_min;
  assign o_disp_sec         = (r_state == ST_IDLE) ? i_cur_sec  : r_sec;
  assign o_adjust_digit_sel = r_sel;
  assign o_blink_on         = r_blink_on;
  assign o_edit_active      = r_edit;
  assign o_load_en          = r_load_en;
  assign o_load_hour        = r_load_hour;
  assign o_load_min         = r_load_min;
  assign o_load_sec         = r_load_sec;

endmodule
`default_nettype wire

// File: doc/fnd_time_adjust_ctrl.md
Name: fnd_time_adjust_ctrl

Overview:
- Edit-mode sequencer for the stopwatch/clock FND display path.
- Takes debounced single-cycle button pulses and the running hour/min/sec values.
- Runs a field-select FSM (hour -> min -> sec) and keeps shadow copies of the fields that the user increments or decrements.
- Drives the per-field adjust select and blink phase toward the display datapath, and issues a one-cycle load strobe that commits the edited time to the time counter.

Parameters:
BLINK_HALF, 250, number of tick_1khz pulses per blink half-period (on or off)
TIMEOUT_TICKS, 10000, number of tick_1khz pulses with no button activity before edit mode aborts

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low (0 = reset)
tick_1khz  input  1  one-cycle enable pulse at 1 kHz
btn_mode  input  1  one-cycle pulse: enter edit / commit
btn_next  input  1  one-cycle pulse: advance to next field
btn_up  input  1  one-cycle pulse: increment selected field
btn_down  input  1  one-cycle pulse: decrement selected field
cur_hour  input  5  running hour, 0-23
cur_min  input  6  running minute, 0-59
cur_sec  input  6  running second, 0-59
disp_hour  output  5  hour value to display
disp_min  output  6  minute value to display
disp_sec  output  6  second value to display
adjust_digit_sel  output  4  one-hot field select: bit3 = sec, bit2 = min, bit1 = hour, bit0 = always 0
blink_on  output  1  blink phase: 1 = selected field visible
edit_active  output  1  1 while in any EDIT state
load_en  output  1  one-cycle commit strobe
load_hour  output  5  committed hour
load_min  output  6  committed minute
load_sec  output  6  committed second

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - Shadow registers, blink counter, blink phase and timeout counter clear to 0.
  - adjust_digit_sel = 0, blink_on = 0, edit_active = 0, load_en = 0, load_* = 0.
  - disp_* follows cur_*.
  - Reset asserted mid-edit discards the edit; no load is issued.
- States are IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC and COMMIT. All outputs except disp_* are registered.
- IDLE:
  - disp_* = cur_* (combinational pass-through).
  - btn_mode captures cur_hour, cur_min and cur_sec into the shadows, then goes to EDIT_HOUR. blink_on = 1 and both counters clear.
  - Other buttons are ignored.
- EDIT_x:
  - disp_* = shadows.
  - adjust_digit_sel is one-hot for the selected field: EDIT_HOUR = 4'b0010, EDIT_MIN = 4'b0100, EDIT_SEC = 4'b1000.
  - edit_active = 1.
- Button priority within a cycle is mode > next > up > down. Only the highest-priority asserted pulse acts.
- btn_mode: go to COMMIT.
- btn_next: cycles HOUR -> MIN -> SEC -> HOUR.
- btn_up on the selected field, with MAX = 23 for hour and 59 for min/sec:
  - Result is 0 if value >= MAX, else value + 1.
- btn_down on the selected field:
  - Result is MAX if value == 0 or value > MAX, else value - 1.
- Out-of-range captured values are held unchanged until they are edited.
- A shadow update made on a button in cycle N is visible on disp_* in cycle N+1.
- Blink:
  - The blink counter counts tick_1khz pulses in EDIT states. At BLINK_HALF-1 with a tick, the counter wraps to 0 and blink_on toggles.
  - Any button pulse clears the counter and forces blink_on = 1 in the next cycle.
- Timeout:
  - The timeout counter counts tick_1khz pulses in EDIT states and clears on any button pulse.
  - A tick arriving with the counter at TIMEOUT_TICKS-1 sends the FSM to IDLE. The edit is discarded: no load_en.
  - A button and the timeout tick in the same cycle: the button wins and the counter clears.
- COMMIT:
  - Entered on cycle N+1 after btn_mode in cycle N.
  - load_en = 1 for exactly that cycle, with load_* = shadows.
  - FSM returns to IDLE in cycle N+2. Buttons arriving during COMMIT are ignored.
- load_* hold their last committed value between commits.
- IDLE: adjust_digit_sel = 0, blink_on = 0, edit_active = 0.

Test Plan:
- Apply rst = 0 mid-edit, then release -> all outputs 0 and disp_* = cur_*. Then pulse btn_mode with cur = 12:34:56 -> edit_active = 1, adjust_digit_sel = 4'b0010, disp = 12:34:56 one cycle later.
- Wrap check: in EDIT_HOUR at shadow 23, btn_up -> 0; btn_down -> 23. In EDIT_MIN at 0, btn_down -> 59; at 59, btn_up -> 0. Sel goes 0010 -> 0100 -> 1000 -> 0010 on three btn_next pulses.
- Commit: edit to 07:08:09, then btn_mode at cycle N -> load_en high only at N+1 with load = 07:08:09. State is IDLE at N+2 with edit_active = 0 and adjust_digit_sel = 0.
- Timeout: with TIMEOUT_TICKS = 20 and BLINK_HALF = 4, no buttons -> blink_on toggles every 4 ticks. The FSM exits to IDLE on the 20th tick with no load_en. A btn_up on tick 19 restarts the count and forces blink_on = 1.
- Priority: btn_mode, btn_next and btn_up asserted together in EDIT_MIN -> COMMIT, shadow unchanged. btn_up and btn_down together -> increment only. btn_up in IDLE -> no state change.
- Out-of-range capture: cur_hour = 30 captured, then btn_up -> 0. Recapture 30, then btn_down -> 23.
